lcd_bus_receiver: RTL and testbench

- Responder end of the 8-bit parallel LCD write bus (wr, dcx, D[7:0]) driven by image_generator.
- Decodes the command/parameter byte stream: CASET, PASET, RAMWR, SWRESET, SLPOUT, DISPON, NOP.
- Emits one addressed RGB565 pixel per completed pixel write.
- Used as an on-FPGA display model for readback/scoring and as the checker front-end in image_generator benches.

---
 rtl/lcd_bus_receiver.sv | 248 ++++++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// Responder end of the 8-bit parallel LCD write bus. It decodes the command and
// parameter stream and emits one addressed RGB565 pixel per completed pixel write.
module lcd_bus_receiver #(
    parameter int COORD_W  = 16,
    parameter int MAX_COL  = 239,
    parameter int MAX_PAGE = 319
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               dcx,
    input  logic [7:0]         D,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_color,
    output logic               frame_done,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               disp_on,
    output logic               sleep_out,
    output logic               bad_cmd
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_IGNORE
    } state_t;

    localparam logic [COORD_W-1:0] EC_RST    = COORD_W'(MAX_COL);
    localparam logic [COORD_W-1:0] EP_RST    = COORD_W'(MAX_PAGE);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

    state_t state_q, state_d;
    logic   wr_q;
    logic   accept;

    logic [1:0] param_cnt_q, param_cnt_d;
    logic       phase_q, phase_d;
    logic [7:0] p0_q, p0_d;
    logic [7:0] p1_q, p1_d;
    logic [7:0] p2_q, p2_d;
    logic [7:0] hi_q, hi_d;

    logic [COORD_W-1:0] sc_q, sc_d;
    logic [COORD_W-1:0] sp_q, sp_d;
    logic [COORD_W-1:0] ec_q, ec_d;
    logic [COORD_W-1:0] ep_q, ep_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d;
    logic [COORD_W-1:0] cur_y_q, cur_y_d;

    logic               pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d;
    logic [COORD_W-1:0] pix_y_q, pix_y_d;
    logic [15:0]        pix_color_q, pix_color_d;
    logic               frame_done_q, frame_done_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_code_q, cmd_code_d;
    logic               disp_on_q, disp_on_d;
    logic               sleep_out_q, sleep_out_d;
    logic               bad_cmd_q, bad_cmd_d;

    // wr_q idles high after reset so a strobe already high is not seen as an edge
    assign accept = wr && !wr_q;

    always_comb begin
        state_d      = state_q;
        param_cnt_d  = param_cnt_q;
        phase_d      = phase_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        hi_d         = hi_q;
        sc_d         = sc_q;
        sp_d         = sp_q;
        ec_d         = ec_q;
        ep_d         = ep_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_color_d  = pix_color_q;
        frame_done_d = 1'b0;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = cmd_code_q;
        disp_on_d    = disp_on_q;
        sleep_out_d  = sleep_out_q;
        bad_cmd_d    = bad_cmd_q;

        if (accept) begin
            if (!dcx) begin
                // Any command aborts the sequence in progress, including a half pixel
                cmd_valid_d = 1'b1;
                cmd_code_d  = D;
                param_cnt_d = 2'd0;
                phase_d     = 1'b0;
                case (D)
                    8'h2A: state_d = ST_CASET;
                    8'h2B: state_d = ST_PASET;
                    8'h2C: begin
                        state_d = ST_RAMWR;
                        cur_x_d = sc_q;
                        cur_y_d = sp_q;
                    end
                    8'h01: begin
                        state_d     = ST_IDLE;
                        sc_d        = '0;
                        sp_d        = '0;
                        ec_d        = EC_RST;
                        ep_d        = EP_RST;
                        disp_on_d   = 1'b0;
                        sleep_out_d = 1'b0;
                    end
                    8'h11: begin
                        state_d     = ST_IDLE;
                        sleep_out_d = 1'b1;
                    end
                    8'h29: begin
                        state_d   = ST_IDLE;
                        disp_on_d = 1'b1;
                    end
                    8'h00: state_d = ST_IDLE;
                    default: begin
                        state_d   = ST_IGNORE;
                        bad_cmd_d = 1'b1;
                    end
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_PASET: begin
                        param_cnt_d = param_cnt_q + 2'd1;
                        case (param_cnt_q)
                            2'd0: p0_d = D;
                            2'd1: p1_d = D;
                            2'd2: p2_d = D;
                            default: begin
                                // Start and end commit together so an aborted window never half-applies
                                state_d = ST_IDLE;
                                if (state_q == ST_CASET) begin
                                    sc_d = COORD_W'({p0_q, p1_q});
                                    ec_d = COORD_W'({p2_q, D});
                                end else begin
                                    sp_d = COORD_W'({p0_q, p1_q});
                                    ep_d = COORD_W'({p2_q, D});
                                end
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!phase_q) begin
                            hi_d    = D;
                            phase_d = 1'b1;
                        end else begin
                            phase_d     = 1'b0;
                            pix_valid_d = 1'b1;
                            pix_color_d = {hi_q, D};
                            pix_x_d     = cur_x_q;
                            pix_y_d     = cur_y_q;
                            // >= rather than == so an inverted window wraps every pixel
                            if (cur_x_q >= ec_q) begin
                                cur_x_d = sc_q;
                                if (cur_y_q >= ep_q) begin
                                    cur_y_d      = sp_q;
                                    frame_done_d = 1'b1;
                                end else begin
                                    cur_y_d = cur_y_q + COORD_ONE;
                                end
                            end else begin
                                cur_x_d = cur_x_q + COORD_ONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q         <= 1'b1;
            state_q      <= ST_IDLE;
            param_cnt_q  <= 2'd0;
            phase_q      <= 1'b0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            hi_q         <= '0;
            sc_q         <= '0;
            sp_q         <= '0;
            ec_q         <= EC_RST;
            ep_q         <= EP_RST;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_color_q  <= '0;
            frame_done_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= '0;
            disp_on_q    <= 1'b0;
            sleep_out_q  <= 1'b0;
            bad_cmd_q    <= 1'b0;
        end else begin
            wr_q         <= wr;
            state_q      <= state_d;
            param_cnt_q  <= param_cnt_d;
            phase_q      <= phase_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            hi_q         <= hi_d;
            sc_q         <= sc_d;
            sp_q         <= sp_d;
            ec_q         <= ec_d;
            ep_q         <= ep_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_color_q  <= pix_color_d;
            frame_done_q <= frame_done_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            disp_on_q    <= disp_on_d;
            sleep_out_q  <= sleep_out_d;
            bad_cmd_q    <= bad_cmd_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_color  = pix_color_q;
    assign frame_done = frame_done_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign disp_on    = disp_on_q;
    assign sleep_out  = sleep_out_q;
    assign bad_cmd    = bad_cmd_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: expected pixels are queued as bytes are
// driven and popped by a monitor whenever the receiver reports a written pixel.
module tb_lcd_bus_receiver;

    logic        clk;
    logic        reset;
    logic        wr;
    logic        dcx;
    logic [7:0]  D;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_color;
    logic        frame_done;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        disp_on;
    logic        sleep_out;
    logic        bad_cmd;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] color;
        logic        fd;
    } pix_t;

    pix_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cmd_cnt = 0;

    lcd_bus_receiver #(
        .COORD_W (16),
        .MAX_COL (239),
        .MAX_PAGE(319)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .dcx       (dcx),
        .D         (D),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .frame_done(frame_done),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .disp_on   (disp_on),
        .sleep_out (sleep_out),
        .bad_cmd   (bad_cmd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus write: wr low with data set up, then a rising edge, then settle time
    task automatic applyStimulus(input logic dc, input logic [7:0] b);
        @(negedge clk);
        wr  = 1'b0;
        dcx = dc;
        D   = b;
        @(negedge clk);
        wr = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic sendPixel(input logic [15:0] color, input int ex, input int ey, input logic fd);
        pix_t e;
        e.x     = 16'(ex);
        e.y     = 16'(ey);
        e.color = color;
        e.fd    = fd;
        exp_q.push_back(e);
        applyStimulus(1'b1, color[15:8]);
        applyStimulus(1'b1, color[7:0]);
    endtask

    task automatic sendWindow(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
        applyStimulus(1'b0, cmd);
        applyStimulus(1'b1, s[15:8]);
        applyStimulus(1'b1, s[7:0]);
        applyStimulus(1'b1, e[15:8]);
        applyStimulus(1'b1, e[7:0]);
    endtask

    // Scoreboard side: every reported pixel must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid === 1'b1) cmd_cnt++;
            if (frame_done === 1'b1) begin
                checks++;
                assert (pix_valid === 1'b1) else begin
                    errors++;
                    $error("[TB] FAIL frame_done_alone observed pix_valid=%0b expected=1", pix_valid);
                end
            end
            if (pix_valid === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL unexpected_pixel observed=(%0d,%0d,%0h) expected=none",
                           pix_x, pix_y, pix_color);
                end
                if (exp_q.size() != 0) begin
                    pix_t e;
                    e = exp_q.pop_front();
                    checks++;
                    assert (pix_x === e.x && pix_y === e.y && pix_color === e.color && frame_done === e.fd)
                    else begin
                        errors++;
                        $error("[TB] FAIL pixel observed=(%0d,%0d,%0h,fd%0b) expected=(%0d,%0d,%0h,fd%0b)",
                               pix_x, pix_y, pix_color, frame_done, e.x, e.y, e.color, e.fd);
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        reset = 1'b1;
        wr    = 1'b0;
        dcx   = 1'b0;
        D     = 8'h29;
        repeat (2) begin
            @(negedge clk) wr = 1'b1;
            @(negedge clk) wr = 1'b0;
        end
        // Release with wr already high and a DISPON on the bus: no edge may be seen
        @(negedge clk);
        wr    = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_pix_valid", pix_valid, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_cmd_valid", cmd_valid, 0);
        checkOutput("rst_cmd_code", cmd_code, 0);
        checkOutput("rst_pix_x", pix_x, 0);
        checkOutput("rst_pix_y", pix_y, 0);
        checkOutput("rst_pix_color", pix_color, 0);
        checkOutput("rst_sleep_out", sleep_out, 0);
        checkOutput("rst_bad_cmd", bad_cmd, 0);
        @(negedge clk);
        checkOutput("rst_disp_on", disp_on, 0);
        checkOutput("rst_cmd_count", cmd_cnt, 0);

        // Aborted CASET leaves the reset window in place
        applyStimulus(1'b0, 8'h2A);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h10);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b0, 8'h2C);
        sendPixel(16'h001F, 0, 0, 1'b0);
        sendPixel(16'h07E0, 1, 0, 1'b0);
        checkOutput("abort_cmd_code", cmd_code, 8'h2C);

        // 3x2 window, one full frame then wrap back to the start corner
        sendWindow(8'h2A, 16'd5, 16'd7);
        sendWindow(8'h2B, 16'd2, 16'd3);
        applyStimulus(1'b0, 8'h2C);
        sendPixel(16'hF800, 5, 2, 1'b0);
        sendPixel(16'hF800, 6, 2, 1'b0);
        sendPixel(16'hF800, 7, 2, 1'b0);
        sendPixel(16'hF800, 5, 3, 1'b0);
        sendPixel(16'hF800, 6, 3, 1'b0);
        sendPixel(16'hF800, 7, 3, 1'b1);
        sendPixel(16'hF800, 5, 2, 1'b0);
        checkOutput("hold_pix_x", pix_x, 5);
        checkOutput("hold_pix_color", pix_color, 16'hF800);

        // Half pixel dropped by a command
        c0 = cmd_cnt;
        applyStimulus(1'b0, 8'h2C);
        applyStimulus(1'b1, 8'hAB);
        applyStimulus(1'b0, 8'h29);
        checkOutput("half_disp_on", disp_on, 1);
        checkOutput("half_cmd_code", cmd_code, 8'h29);
        checkOutput("half_cmd_pulses", cmd_cnt - c0, 2);
        applyStimulus(1'b0, 8'h2C);
        sendPixel(16'h1234, 5, 2, 1'b0);

        applyStimulus(1'b0, 8'h11);
        checkOutput("slpout", sleep_out, 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("nop_cmd_code", cmd_code, 8'h00);
        checkOutput("nop_disp_on", disp_on, 1);

        // Inverted window wraps on every pixel
        sendWindow(8'h2A, 16'd8, 16'd2);
        sendWindow(8'h2B, 16'd4, 16'd1);
        applyStimulus(1'b0, 8'h2C);
        sendPixel(16'hAAAA, 8, 4, 1'b1);
        sendPixel(16'h5555, 8, 4, 1'b1);

        // Unknown opcode: data ignored, sticky bad_cmd survives SWRESET
        applyStimulus(1'b0, 8'h36);
        applyStimulus(1'b1, 8'h12);
        applyStimulus(1'b1, 8'h34);
        checkOutput("bad_cmd_set", bad_cmd, 1);
        applyStimulus(1'b0, 8'h01);
        checkOutput("swreset_bad_cmd", bad_cmd, 1);
        checkOutput("swreset_disp_on", disp_on, 0);
        checkOutput("swreset_sleep_out", sleep_out, 0);

        // Full-width row proves EC back at 239
        applyStimulus(1'b0, 8'h2C);
        for (int i = 0; i < 241; i++) begin
            sendPixel(16'(i * 7 + 3), i % 240, i / 240, 1'b0);
        end

        // Single-column window proves EP back at 319
        sendWindow(8'h2A, 16'd0, 16'd0);
        applyStimulus(1'b0, 8'h2C);
        for (int i = 0; i < 321; i++) begin
            sendPixel(16'(i * 5 + 1), 0, i % 320, (i == 319) ? 1'b1 : 1'b0);
        end

        repeat (4) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
